// File: rtl/vec_sequencer.sv
// -----------------------------------------------------------------------------
// vec_sequencer
//
// Multicycle controller that walks the vector register file and vector ALU
// through one vector instruction, one element per READ -> EXEC -> WRITE pass.
// While an op is in flight the scalar PC / instruction path is stalled.
//
// Optional feature (compile-time macro VEC_SEQUENCER_FLAGS_EN):
//   accumulates the per-element VALU flags {N,Z,C,V} into acc_flags.
//   Without the macro acc_flags is tied to zero and lane_flags is ignored.
//
// Ports:
//   clk        in   rising-edge system clock
//   reset      in   asynchronous active-low reset
//   start      in   decoded vector instruction valid, sampled only in IDLE
//   vlen       in   requested element count (clamped to MAX_VLEN)
//   vwe_req    in   instruction writes its destination, captured at accept
//   flush      in   synchronous cancel of the op in flight
//   lane_flags in   VALU flags {N,Z,C,V} for the current element
//   busy       out  op in flight (state != IDLE)
//   stall      out  hold PC/Instr: busy | (start & IDLE)
//   elem_idx   out  current element index
//   vrf_re     out  vector RF read strobe
//   valu_en    out  VALU operand/result capture enable
//   vrf_we     out  vector RF write enable (killed by flush)
//   done       out  one-cycle completion pulse
//   acc_flags  out  accumulated flags {N,Z,C,V} (optional feature)
// -----------------------------------------------------------------------------
module vec_sequencer #(
  parameter int unsigned MAX_VLEN = 5,
  parameter int unsigned VLEN_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [VLEN_W-1:0] vlen,
  input  logic              vwe_req,
  input  logic              flush,
  input  logic [3:0]        lane_flags,
  output logic              busy,
  output logic              stall,
  output logic [VLEN_W-1:0] elem_idx,
  output logic              vrf_re,
  output logic              valu_en,
  output logic              vrf_we,
  output logic              done,
  output logic [3:0]        acc_flags
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [VLEN_W-1:0] MAX_Q = VLEN_W'(MAX_VLEN);
  localparam logic [VLEN_W-1:0] ONE_Q = VLEN_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [VLEN_W-1:0] r_elem_idx;
  logic [VLEN_W-1:0] w_elem_next;
  logic [VLEN_W-1:0] r_vlen_q;
  logic              r_vwe_q;
  logic [VLEN_W-1:0] w_vlen_clamped;
  logic              w_accept;
  logic              w_accept_run;
  logic              w_last;
  logic              w_kill;

  assign w_vlen_clamped = (vlen > MAX_Q) ? MAX_Q : vlen;
  assign w_accept       = (r_state == S_IDLE) && start;
  assign w_accept_run   = w_accept && (vlen != '0);
  assign w_last         = (r_elem_idx == (r_vlen_q - ONE_Q));
  // flush only has meaning once an op is in flight
  assign w_kill         = flush && (r_state != S_IDLE);

  // State and element index register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_elem_idx <= '0;
    end else begin
      r_state    <= w_next;
      r_elem_idx <= w_elem_next;
    end
  end

  // Operation parameters latched at accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vlen_q <= '0;
      r_vwe_q  <= 1'b0;
    end else if (w_accept_run) begin
      r_vlen_q <= w_vlen_clamped;
      r_vwe_q  <= vwe_req;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    w_next      = r_state;
    w_elem_next = r_elem_idx;
    busy        = 1'b1;
    vrf_re      = 1'b0;
    valu_en     = 1'b0;
    vrf_we      = 1'b0;
    done        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        busy        = 1'b0;
        w_elem_next = '0;
        if (start) begin
          w_next = (vlen == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        vrf_re = 1'b1;
        w_next = S_EXEC;
      end
      S_EXEC: begin
        valu_en = 1'b1;
        w_next  = S_WRITE;
      end
      S_WRITE: begin
        vrf_we = r_vwe_q;
        if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next      = S_READ;
          w_elem_next = r_elem_idx + ONE_Q;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_next      = S_IDLE;
        w_elem_next = '0;
      end
      default: begin
        busy        = 1'b0;
        w_next      = S_IDLE;
        w_elem_next = '0;
      end
    endcase

    // Flush overrides everything: abandon the op and suppress the write
    // that would otherwise land in this cycle.
    if (w_kill) begin
      w_next      = S_IDLE;
      w_elem_next = '0;
      vrf_we      = 1'b0;
    end
  end

  assign stall    = busy || w_accept;
  assign elem_idx = r_elem_idx;

`ifdef VEC_SEQUENCER_FLAGS_EN
  logic [3:0] r_acc_flags;

  // N, C, V are sticky-OR across elements; Z is AND (all elements zero).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc_flags <= '0;
    end else if (w_accept) begin
      r_acc_flags <= 4'b0100;
    end else if ((r_state == S_WRITE) && !flush) begin
      r_acc_flags <= {r_acc_flags[3] | lane_flags[3],
                      r_acc_flags[2] & lane_flags[2],
                      r_acc_flags[1] | lane_flags[1],
                      r_acc_flags[0] | lane_flags[0]};
    end
  end

  assign acc_flags = r_acc_flags;
`else
  logic w_unused_lane_flags;

  assign w_unused_lane_flags = ^lane_flags;
  assign acc_flags           = '0;
`endif

endmodule

// File: tb/tb_vec_sequencer.sv
module tb_vec_sequencer;

  localparam int MAXV = 5;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] vlen;
  logic       vwe_req;
  logic       flush;
  logic [3:0] lane_flags;
  logic       busy;
  logic       stall;
  logic [2:0] elem_idx;
  logic       vrf_re;
  logic       valu_en;
  logic       vrf_we;
  logic       done;
  logic [3:0] acc_flags;

  logic [3:0] lane_pat [0:7];
  logic [2:0] wq [$];

  int tests = 0;
  int fails = 0;

  vec_sequencer #(
    .MAX_VLEN(5),
    .VLEN_W  (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .vlen      (vlen),
    .vwe_req   (vwe_req),
    .flush     (flush),
    .lane_flags(lane_flags),
    .busy      (busy),
    .stall     (stall),
    .elem_idx  (elem_idx),
    .vrf_re    (vrf_re),
    .valu_en   (valu_en),
    .vrf_we    (vrf_we),
    .done      (done),
    .acc_flags (acc_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VALU stand-in: flags presented for whichever element is current
  assign lane_flags = lane_pat[elem_idx];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every write pulse must match the next expected index
  always @(negedge clk) begin
    #2;
    if (reset && vrf_we) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", {31'd0, vrf_we}, 32'd0);
      end else begin
        logic [2:0] e;
        e = wq.pop_front();
        chk("write_idx", {29'd0, elem_idx}, {29'd0, e});
      end
    end
  end

  // Called at a negedge with the DUT idle. flush_k: write index to flush on
  // (-1 none). rst_c: cycle after accept at which reset is pulsed (0 none).
  task automatic run_op(input int vl, input bit we, input int flush_k, input int rst_c);
    int n, last, ph, ix;
    int nre, nen, ndone;
    logic [3:0] ef;
    logic [8:0] ev, ov;
    n    = (vl > MAXV) ? MAXV : vl;
    last = 3 * n + 1;
    ef   = 4'b0100;
    nre  = 0; nen = 0; ndone = 0;
    for (int i = 0; i < n; i++) begin
      if (flush_k >= 0 && i >= flush_k) break;
      if (rst_c > 0 && 3 * i + 3 >= rst_c) break;
      if (we) wq.push_back(i[2:0]);
      ef = {ef[3] | lane_pat[i][3], ef[2] & lane_pat[i][2],
            ef[1] | lane_pat[i][1], ef[0] | lane_pat[i][0]};
    end

    start   = 1'b1;
    vlen    = vl[2:0];
    vwe_req = we;
    #1;
    chk("stall_at_start", {31'd0, stall}, 32'd1);
    chk("busy_at_start", {31'd0, busy}, 32'd0);

    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      if (c == last) start = 1'b0;
      flush = (flush_k >= 0) && (c == 3 * flush_k + 3);
      if (flush) start = 1'b0;
      #1;
      // expected {vrf_we,busy,stall,vrf_re,valu_en,done,elem_idx}
      if (c < last) begin
        ph = (c - 1) % 3;
        ix = (c - 1) / 3;
        ev = {(ph == 2) && we && !flush, 1'b1, 1'b1, ph == 0, ph == 1, 1'b0, ix[2:0]};
      end else if (c == last) begin
        ix = (n > 0) ? n - 1 : 0;
        ev = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ix[2:0]};
      end else begin
        ev = 9'd0;
      end
      ov = {vrf_we, busy, stall, vrf_re, valu_en, done, elem_idx};
      chk($sformatf("cycle%0d_outputs", c), {23'd0, ov}, {23'd0, ev});
      nre   += vrf_re;
      nen   += valu_en;
      ndone += done;
      if (c == last) begin
`ifdef VEC_SEQUENCER_FLAGS_EN
        chk("acc_flags_at_done", {28'd0, acc_flags}, {28'd0, ef});
`else
        chk("acc_flags_tied", {28'd0, acc_flags}, 32'd0);
`endif
      end

      if (flush) begin
        @(negedge clk);
        flush = 1'b0;
        #1;
        ov = {vrf_we, busy, stall, vrf_re, valu_en, done, elem_idx};
        chk("after_flush_idle", {23'd0, ov}, 32'd0);
        return;
      end

      if (c == rst_c) begin
        reset = 1'b0;
        start = 1'b0;
        #1;
        ov = {vrf_we, busy, stall, vrf_re, valu_en, done, elem_idx};
        chk("async_reset_outputs", {23'd0, ov}, 32'd0);
        chk("async_reset_flags", {28'd0, acc_flags}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("post_reset_busy", {31'd0, busy}, 32'd0);
        chk("post_reset_idx", {29'd0, elem_idx}, 32'd0);
        return;
      end
    end
    chk("vrf_re_pulses", nre, n);
    chk("valu_en_pulses", nen, n);
    chk("done_pulses", ndone, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) lane_pat[i] = 4'b0100;
    reset   = 1'b0;
    start   = 1'b0;
    vlen    = '0;
    vwe_req = 1'b0;
    flush   = 1'b0;

    @(negedge clk);
    #1;
    chk("reset_outputs",
        {23'd0, vrf_we, busy, stall, vrf_re, valu_en, done, elem_idx}, 32'd0);
    chk("reset_flags", {28'd0, acc_flags}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // nominal three-element op
    run_op(3, 1'b1, -1, 0);
    @(negedge clk);
    // zero-length op goes straight to DONE
    run_op(0, 1'b1, -1, 0);
    @(negedge clk);
    // over-length request clamps to MAX_VLEN
    run_op(7, 1'b1, -1, 0);
    @(negedge clk);
    // flush on the second write, then a fresh op two cycles later
    run_op(4, 1'b1, 1, 0);
    @(negedge clk);
    run_op(2, 1'b1, -1, 0);
    @(negedge clk);
    // flag accumulation across two elements
    lane_pat[0] = 4'b0100;
    lane_pat[1] = 4'b1010;
    run_op(2, 1'b1, -1, 0);
    @(negedge clk);
    // no-write op: same timing, no write strobes
    run_op(2, 1'b0, -1, 0);
    @(negedge clk);
    // asynchronous reset while in EXEC of element 2
    run_op(3, 1'b1, -1, 8);
    @(negedge clk);
    // single element op right after reset recovery
    run_op(1, 1'b1, -1, 0);
    @(negedge clk);
    #3;

    chk("scoreboard_drained", wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
